// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and load/store, serialising 1/2/4-byte accesses.
// Build option MEMARB_RR_EN: simultaneous requests alternate (round-robin) instead of MEM always winning.
module mem_arbiter #(
  parameter int RAM_ADDR_W = 17,
  parameter int RAM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_ack,
  output logic [31:0]           if_data,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_len,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_ack,
  output logic [31:0]           mem_rdata,
  output logic [RAM_ADDR_W-1:0] ram_a,
  output logic [7:0]            ram_dout,
  output logic                  ram_wr,
  input  logic [7:0]            ram_din,
  output logic                  stall_req_if,
  output logic                  stall_req_mem
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

  state_t                state;
  logic [RAM_ADDR_W-1:0] base;
  logic [2:0]            len;
  logic                  sel_mem;
  logic [31:0]           wdata;
  logic [31:0]           rbuf;
  logic [3:0]            cyc;
  logic                  wr_q;
`ifdef MEMARB_RR_EN
  logic                  last_mem;
`endif

  logic                  grant_any;
  logic                  grant_mem;
  logic [2:0]            req_len;
  logic [RAM_ADDR_W-1:0] grant_addr;
  logic [3:0]            last_cyc;
  logic                  cap_en;
  logic [1:0]            cap_idx;
  logic [31:0]           rbuf_next;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[31:RAM_ADDR_W], mem_addr[31:RAM_ADDR_W]};

  // Grant selection for the IDLE cycle
  always_comb begin
    grant_any = if_req | mem_req;
`ifdef MEMARB_RR_EN
    grant_mem = mem_req & ~(if_req & last_mem);
`else
    grant_mem = mem_req;
`endif
    if (grant_mem) begin
      grant_addr = mem_addr[RAM_ADDR_W-1:0];
    end else begin
      grant_addr = if_addr[RAM_ADDR_W-1:0];
    end
    case (mem_len)
      2'b00:   req_len = 3'd1;
      2'b01:   req_len = 3'd2;
      default: req_len = 3'd4;
    endcase
  end

  // Read byte k-1 arrives RAM_LAT cycles after its address, i.e. in cycle k+RAM_LAT
  always_comb begin
    last_cyc  = {1'b0, len} + 4'(RAM_LAT);
    cap_en    = (cyc > 4'(RAM_LAT)) && (cyc <= last_cyc);
    cap_idx   = 2'(cyc - 4'(RAM_LAT + 1));
    if (cap_en) begin
      rbuf_next = rbuf | ({24'd0, ram_din} << {cap_idx, 3'b000});
    end else begin
      rbuf_next = rbuf;
    end
  end

  assign ram_wr        = wr_q & rdy;
  assign stall_req_if  = if_req & ~if_ack;
  assign stall_req_mem = mem_req & ~mem_ack;

  // Arbitration FSM, byte sequencing and registered outputs; rdy low freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      len       <= 3'd0;
      sel_mem   <= 1'b0;
      wdata     <= 32'd0;
      rbuf      <= 32'd0;
      cyc       <= 4'd0;
      wr_q      <= 1'b0;
      ram_a     <= '0;
      ram_dout  <= 8'd0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_data   <= 32'd0;
      mem_rdata <= 32'd0;
`ifdef MEMARB_RR_EN
      last_mem  <= 1'b0;
`endif
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            sel_mem <= grant_mem;
            base    <= grant_addr;
            ram_a   <= grant_addr;
            len     <= grant_mem ? req_len : 3'd4;
            wdata   <= mem_wdata;
            rbuf    <= 32'd0;
            cyc     <= 4'd1;
`ifdef MEMARB_RR_EN
            last_mem <= grant_mem;
`endif
            if (grant_mem && mem_we) begin
              wr_q     <= 1'b1;
              ram_dout <= mem_wdata[7:0];
              state    <= WRITE;
            end else begin
              state    <= READ;
            end
          end
        end
        READ: begin
          cyc  <= cyc + 4'd1;
          rbuf <= rbuf_next;
          if (cyc < {1'b0, len}) begin
            ram_a <= base + RAM_ADDR_W'(cyc);
          end
          if (cyc == last_cyc) begin
            state <= DONE;
            if (sel_mem) begin
              mem_ack   <= 1'b1;
              mem_rdata <= rbuf_next;
            end else begin
              if_ack  <= 1'b1;
              if_data <= rbuf_next;
            end
          end
        end
        WRITE: begin
          cyc <= cyc + 4'd1;
          if (cyc < {1'b0, len}) begin
            ram_a    <= base + RAM_ADDR_W'(cyc);
            ram_dout <= wdata[{cyc[1:0], 3'b000} +: 8];
          end else begin
            wr_q    <= 1'b0;
            mem_ack <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if_ack  <= 1'b0;
          mem_ack <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
